fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the MIPS control unit. It holds the program counter and issues word reads to instruction memory over a req/ack handshake. It latches the returned word into an instruction register and presents opcode/funct and the full instruction to decode with a valid/ready handshake. It also applies next-PC redirects (branch, j/jal, jr) fed back from the decode/execute side.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  instruction memory read request
imem_addr  output  32  word address of requested instruction, bits[1:0] always 00
imem_ack  input  1  memory returns imem_rdata this cycle
imem_rdata  input  32  instruction word, valid only with imem_ack
instr  output  32  instruction register
opcode  output  6  instr[31:26], to control unit
funct  output  6  instr[5:0], to control unit
pc  output  32  address of instr
pc_plus4  output  32  pc+4, used as the jal link value
instr_valid  output  1  instr/opcode/funct/pc valid
instr_ready  input  1  downstream consumes instr this cycle
branch_taken  input  1  redirect to branch target
branch_offset  input  16  branch immediate, signed, in words
jump  input  1  redirect to j/jal target
jump_index  input  26  instr_index field
jr  input  1  redirect to register target
jr_target  input  32  register value for jr
fault  output  1  sticky misaligned-jr flag

Behaviour:
- Reset (async, rst_n=0): state=RST; imem_req=0, imem_addr=RESET_PC, instr=0, pc=RESET_PC, pc_plus4=RESET_PC+4, instr_valid=0, fault=0. Internal fetch_pc=RESET_PC.
- FSM states: RST, FETCH, HOLD.
- RST: always moves to FETCH on the first clock after rst_n rises.
- FETCH: imem_req=1, imem_addr=fetch_pc. imem_addr is held stable until ack.
  - On imem_ack: instr<=imem_rdata, pc<=fetch_pc, pc_plus4<=fetch_pc+4, go to HOLD.
  - imem_req is 0 in the cycle after ack.
  - Ack latency is unbounded; a same-cycle ack (request and ack in one cycle) is legal.
- HOLD: instr_valid=1 and imem_req=0. instr, pc, pc_plus4, opcode and funct stay stable while instr_ready=0.
  - On instr_valid && instr_ready (handshake), sample the redirects and load fetch_pc, then go to FETCH.
  - instr_valid is 0 in the following cycle.
- Next-PC rule, evaluated only on the handshake cycle. Priority is jr > jump > branch_taken > sequential:
  - jr: {jr_target[31:2],2'b00}; if jr_target[1:0]!=0, set fault (sticky until reset).
  - jump: {pc_plus4[31:28], jump_index, 2'b00}.
  - branch_taken: pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00}, modulo 2^32.
  - otherwise: pc_plus4.
- Redirect inputs are ignored outside the handshake cycle.
- Arithmetic is 32-bit wrap-around: pc=32'hFFFF_FFFC gives pc_plus4=0.
- Throughput: at most one instruction per 2 cycles (FETCH->HOLD). Minimum latency is 1 cycle from imem_req to instr_valid with a same-cycle ack.
- Reset mid-operation (in FETCH waiting for ack, or in HOLD): all outputs return to reset values immediately. A late imem_ack after reset is ignored while in RST.
- opcode and funct are pure slices of instr, with no extra register.

Test Plan:
- Reset, then release with ack delayed 3 cycles and imem_rdata=32'h2009_0005 -> imem_req=1, imem_addr=0 for 4 cycles; then instr_valid=1, opcode=6'h08, pc=0, pc_plus4=4.
- Sequential flow with instr_ready held 0 for 5 cycles -> instr and pc stable and imem_req=0 throughout; after ready, next imem_addr=4.
- At pc=32'h0000_0010, branch_taken=1, branch_offset=16'hFFFE at handshake -> next imem_addr=32'h0000_000C.
- At pc=32'h4000_0000, jump=1 and branch_taken=1, jump_index=26'h000_0040 -> imem_addr=32'h4000_0100 (jump wins).
- jr=1, jr_target=32'h0000_0103 -> imem_addr=32'h0000_0100 and fault=1, held through later fetches.
- rst_n low while waiting for ack, then ack arrives during reset -> instr_valid=0, instr=0; after release, imem_addr=RESET_PC.
- pc=32'hFFFF_FFFC sequential -> pc_plus4=0, next imem_addr=0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the MIPS control unit.
// Holds the PC and fetches one word at a time from instruction memory
// over a req/ack handshake. The returned word is held in an instruction
// register and offered to decode over a valid/ready handshake. The
// decode/execute side supplies next-PC redirects (jr, j/jal, branch),
// which are sampled only on the cycle the instruction is consumed.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    // instruction memory side
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    // decode side
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    // redirects from decode/execute
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    // sticky misaligned-jr flag
    output logic        fault
);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC_PLUS4 = RESET_PC + 32'd4;

    state_t      state_q;
    logic [31:0] fetch_pc_q;
    logic        req_q;
    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic [31:0] pc_plus4_q;
    logic        valid_q;
    logic        fault_q;

    logic        handshake;
    logic [31:0] branch_disp;
    logic [31:0] next_pc_d;
    logic        fault_d;

    // Redirect target selection; only consumed on the handshake cycle.
    // Priority: jr beats jump beats taken branch beats sequential.
    always_comb begin
        handshake   = valid_q && instr_ready;
        branch_disp = {{14{branch_offset[15]}}, branch_offset, 2'b00};
        next_pc_d   = pc_plus4_q;
        fault_d     = fault_q;
        if (jr) begin
            next_pc_d = {jr_target[31:2], 2'b00};
            fault_d   = fault_q | (jr_target[1:0] != 2'b00);
        end else if (jump) begin
            next_pc_d = {pc_plus4_q[31:28], jump_index, 2'b00};
        end else if (branch_taken) begin
            next_pc_d = pc_plus4_q + branch_disp;
        end
    end

    // Fetch FSM with all outputs registered; reset clears everything at once,
    // so an ack still in flight when reset hits is simply dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RST;
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            instr_q    <= 32'd0;
            pc_q       <= RESET_PC;
            pc_plus4_q <= RESET_PC_PLUS4;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_RST: begin
                    // Any ack seen here belongs to a pre-reset request.
                    state_q <= ST_FETCH;
                    req_q   <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        instr_q    <= imem_rdata;
                        pc_q       <= fetch_pc_q;
                        pc_plus4_q <= fetch_pc_q + 32'd4;
                        req_q      <= 1'b0;
                        valid_q    <= 1'b1;
                        state_q    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (handshake) begin
                        fetch_pc_q <= next_pc_d;
                        fault_q    <= fault_d;
                        valid_q    <= 1'b0;
                        req_q      <= 1'b1;
                        state_q    <= ST_FETCH;
                    end
                end
                default: begin
                    state_q <= ST_RST;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Address is the fetch PC register itself, so it cannot move before ack.
    assign imem_req    = req_q;
    assign imem_addr   = fetch_pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign funct       = instr_q[5:0];
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_q;
    assign instr_valid = valid_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed fetch/redirect scenarios. Stimulus
// pushes the expected instruction record into a queue; a monitor pops and
// compares whenever a new instruction appears on the decode side.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic        fault;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
        logic [5:0]  opcode;
        logic [5:0]  funct;
    } exp_t;

    exp_t exp_q[$];

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .opcode        (opcode),
        .funct         (funct),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .jr            (jr),
        .jr_target     (jr_target),
        .fault         (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, expv);
        end
    endtask

    // Monitor: compare each newly presented instruction against the queue head.
    logic valid_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            valid_prev = 1'b0;
        end else begin
            if (instr_valid && !valid_prev) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_instr: got pc=%08h with no expectation queued", pc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("mon_pc", pc, e.pc);
                    chk("mon_pc_plus4", pc_plus4, e.pc_plus4);
                    chk("mon_instr", instr, e.instr);
                    chk("mon_opcode", {26'd0, opcode}, {26'd0, e.opcode});
                    chk("mon_funct", {26'd0, funct}, {26'd0, e.funct});
                    $display("instr pc=%08h pc_plus4=%08h instr=%08h op=%02h fn=%02h",
                             pc, pc_plus4, instr, opcode, funct);
                end
            end
            valid_prev = instr_valid;
        end
    end

    // Wait for a request, hold ack off for 'delay' cycles, then return data.
    task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] data,
                            input logic [5:0] exp_op, input logic [5:0] exp_fn,
                            input int delay);
        exp_t e;
        int   n;
        e.pc       = exp_addr;
        e.pc_plus4 = exp_addr + 32'd4;
        e.instr    = data;
        e.opcode   = exp_op;
        e.funct    = exp_fn;
        exp_q.push_back(e);
        imem_ack = 1'b0;
        n = 0;
        while (!imem_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) begin
            total++;
            bad++;
            $display("FAIL req_timeout: imem_req=0 expected 1 within 100 cycles");
            return;
        end
        chk("fetch_addr", imem_addr, exp_addr);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, exp_addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        chk("req_after_ack", {31'd0, imem_req}, 32'd0);
        chk("valid_after_ack", {31'd0, instr_valid}, 32'd1);
    endtask

    // Stall for 'stall' cycles with junk redirects, then hand off with redirects.
    task automatic handoff(input int stall, input logic j_r, input logic [31:0] j_t,
                           input logic jmp, input logic [25:0] jidx,
                           input logic br, input logic [15:0] off, input logic exp_fault);
        logic [31:0] hold_instr;
        logic [31:0] hold_pc;
        hold_instr = instr;
        hold_pc    = pc;
        for (int i = 0; i < stall; i++) begin
            instr_ready  = 1'b0;
            jr           = 1'b1;
            jr_target    = 32'h0000_0501;
            jump         = 1'b1;
            branch_taken = 1'b1;
            @(negedge clk);
            chk("stall_instr", instr, hold_instr);
            chk("stall_pc", pc, hold_pc);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
        end
        instr_ready   = 1'b1;
        jr            = j_r;
        jr_target     = j_t;
        jump          = jmp;
        jump_index    = jidx;
        branch_taken  = br;
        branch_offset = off;
        @(negedge clk);
        instr_ready  = 1'b0;
        jr           = 1'b0;
        jump         = 1'b0;
        branch_taken = 1'b0;
        chk("post_hs_valid", {31'd0, instr_valid}, 32'd0);
        chk("post_hs_req", {31'd0, imem_req}, 32'd1);
        chk("fault", {31'd0, fault}, {31'd0, exp_fault});
    endtask

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; instr_ready = 1'b0;
        branch_taken = 1'b0; branch_offset = 16'd0; jump = 1'b0; jump_index = 26'd0;
        jr = 1'b0; jr_target = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);   // RST -> FETCH happens at the next edge

        // addi $t1,$zero,5 with ack after 3 wait cycles
        do_fetch(32'h0000_0000, 32'h2009_0005, 6'h08, 6'h05, 3);
        handoff(5, 0, 0, 0, 0, 0, 0, 0);                        // sequential -> 4
        do_fetch(32'h0000_0004, 32'h012A_4020, 6'h00, 6'h20, 0); // add, same-cycle ack
        handoff(0, 1, 32'h0000_0010, 0, 0, 0, 0, 0);             // jr -> 0x10
        do_fetch(32'h0000_0010, 32'h1000_FFFE, 6'h04, 6'h3E, 1); // beq
        handoff(1, 0, 0, 0, 0, 1, 16'hFFFE, 0);                  // 0x14 - 8 = 0x0C
        do_fetch(32'h0000_000C, 32'h0000_0008, 6'h00, 6'h08, 0);
        handoff(0, 1, 32'h4000_0000, 0, 0, 0, 0, 0);             // jr -> 0x4000_0000
        do_fetch(32'h4000_0000, 32'h0C00_0040, 6'h03, 6'h00, 2); // jal
        handoff(0, 0, 0, 1, 26'h000_0040, 1, 16'h0010, 0);       // jump wins -> 0x4000_0100
        do_fetch(32'h4000_0100, 32'h0800_0001, 6'h02, 6'h01, 0);
        handoff(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);             // jr -> top word
        do_fetch(32'hFFFF_FFFC, 32'hAC00_0000, 6'h2B, 6'h00, 0);
        chk("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
        handoff(0, 0, 0, 0, 0, 0, 0, 0);                         // wraps to 0
        do_fetch(32'h0000_0000, 32'h0000_0009, 6'h00, 6'h09, 0);
        handoff(0, 1, 32'h0000_0103, 0, 0, 0, 0, 1);             // misaligned jr
        do_fetch(32'h0000_0100, 32'h8C00_0004, 6'h23, 6'h04, 1);
        handoff(2, 0, 0, 0, 0, 0, 0, 1);                         // fault stays set
        do_fetch(32'h0000_0104, 32'h0000_0000, 6'h00, 6'h00, 0);
        handoff(0, 0, 0, 0, 0, 0, 0, 1);

        // Reset while 0x108 is waiting for ack; the ack lands during reset.
        chk("prerst_addr", imem_addr, 32'h0000_0108);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_pc_plus4", pc_plus4, 32'h4);
        chk("mid_rst_fault", {31'd0, fault}, 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        repeat (2) @(negedge clk);
        chk("late_ack_valid", {31'd0, instr_valid}, 32'd0);
        chk("late_ack_instr", instr, 32'h0);
        rst_n    = 1'b1;
        imem_ack = 1'b0;
        do_fetch(32'h0000_0000, 32'h2009_0005, 6'h08, 6'h05, 0);
        handoff(0, 0, 0, 0, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drained: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
